// File: rtl/aes_dec_ctrl.sv
// ---------------------------------------------------------------------------
// aes_dec_ctrl
// Sequencer for the AES inverse cipher. Drives the aes_dec datapath
// (InvShiftRows / InvSubBytes / AddRoundKey / InvMixColumns) and key_gen in
// inverse-expansion mode. The single S-box is time-shared between the data
// path and key_gen, which is why every AESDECFULL round is split into an
// SBOX cycle (key_gen owns the S-box and steps K(i) -> K(i-1)) followed by a
// ROUND cycle (the data path owns the S-box and consumes that key).
//
// Optional feature: define AES_DEC_ABORT_EN to add the abort_i input, which
// cancels a running command and returns the controller to its reset values
// without issuing a ready pulse.
//
// Outputs are decoded combinationally from the state, the latched opcode and
// (in IDLE) the incoming command, so the datapath sees the first-cycle
// controls in the same cycle the command is presented.
// ---------------------------------------------------------------------------
module aes_dec_ctrl #(
  parameter int          NR        = 10,
  parameter logic [7:0]  RCON_LAST = 8'h36
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start_i,
  input  logic [2:0]  opcode_i,
`ifdef AES_DEC_ABORT_EN
  input  logic        abort_i,
`endif
  output logic        first_rnd_o,
  output logic        last_rnd_o,
  output logic        key_sel_o,
  output logic        imc_only_o,
  output logic        key_sub_o,
  output logic        inv_key_o,
  output logic        en_rnd_o,
  output logic        en_key_o,
  output logic        plain_ready_o,
  output logic        key_ready_o,
  output logic        busy_o,
  // 32-bit rcon word for key_gen: byte[3] = rcon, bytes[2:0] = 0
  output logic [31:0] r_con_ctrl_o
);

  // Command encodings
  localparam logic [2:0] OP_NOOP    = 3'd0;
  localparam logic [2:0] OP_DEC     = 3'd1;
  localparam logic [2:0] OP_DECLAST = 3'd2;
  localparam logic [2:0] OP_IMC     = 3'd3;
  localparam logic [2:0] OP_DECFULL = 3'd4;

  // Round counter value at which the final DECFULL round executes
  localparam logic [3:0] NR_CNT = 4'(NR);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SBOX   = 2'd1,
    ROUND  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [3:0]  rnd_cnt_q, rnd_cnt_d;
  logic [7:0]  rcon_q, rcon_d;

  logic        abort_s;
  logic        legal_start_s;
  logic        first_rnd_s;
  logic        last_rnd_s;
  logic        key_sel_s;
  logic        imc_only_s;
  logic        key_sub_s;
  logic        inv_key_s;
  logic        en_rnd_s;
  logic        en_key_s;
  logic        plain_ready_s;
  logic        key_ready_s;
  logic        busy_s;

`ifdef AES_DEC_ABORT_EN
  assign abort_s = abort_i;
`else
  assign abort_s = 1'b0;
`endif

  // A command is accepted only for the four defined non-NOOP opcodes
  assign legal_start_s = start_i &&
                         ((opcode_i == OP_DEC)  || (opcode_i == OP_DECLAST) ||
                          (opcode_i == OP_IMC)  || (opcode_i == OP_DECFULL));

  // Next-state, datapath counters and output decode
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    rnd_cnt_d     = rnd_cnt_q;
    rcon_d        = rcon_q;
    first_rnd_s   = 1'b0;
    last_rnd_s    = 1'b0;
    key_sel_s     = 1'b0;
    imc_only_s    = 1'b0;
    key_sub_s     = 1'b0;
    inv_key_s     = 1'b0;
    en_rnd_s      = 1'b1;
    en_key_s      = 1'b1;
    plain_ready_s = 1'b0;
    key_ready_s   = 1'b0;
    busy_s        = 1'b0;

    case (state_q)
      IDLE: begin
        if (abort_s) begin
          // abort beats a simultaneous start: nothing is latched
          state_d = IDLE;
        end else if (legal_start_s) begin
          busy_s = 1'b1;
          op_d   = opcode_i;
          case (opcode_i)
            OP_DEC, OP_DECLAST: begin
              // key operand is external, key_gen stays frozen
              en_key_s = 1'b0;
              state_d  = SBOX;
            end
            OP_IMC: begin
              // only the key path works on an AESIMC
              en_rnd_s = 1'b0;
              state_d  = ROUND;
            end
            OP_DECFULL: begin
              // initial AddRoundKey with the external K(NR)
              first_rnd_s = 1'b1;
              key_sel_s   = 1'b0;
              rnd_cnt_d   = 4'd1;
              rcon_d      = RCON_LAST;
              state_d     = SBOX;
            end
            default: begin
              state_d = IDLE;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end

      SBOX: begin
        busy_s = 1'b1;
        if (op_q == OP_DECFULL) begin
          // key_gen borrows the S-box to form K(NR-rnd_cnt); data path waits
          key_sub_s = 1'b1;
          inv_key_s = 1'b1;
          en_rnd_s  = 1'b0;
        end else begin
          key_sub_s = 1'b0;
        end
        state_d = ROUND;
      end

      ROUND: begin
        busy_s = 1'b1;
        case (op_q)
          OP_DEC: begin
            key_sel_s = 1'b0;
            state_d   = FINISH;
          end
          OP_DECLAST: begin
            key_sel_s  = 1'b0;
            last_rnd_s = 1'b1;
            state_d    = FINISH;
          end
          OP_IMC: begin
            imc_only_s = 1'b1;
            state_d    = FINISH;
          end
          OP_DECFULL: begin
            key_sub_s = 1'b0;
            key_sel_s = 1'b1;
            // inverse rcon walk: 0x1b wraps back to 0x80, otherwise halve
            if (rcon_q == 8'h1b) begin
              rcon_d = 8'h80;
            end else begin
              rcon_d = {1'b0, rcon_q[7:1]};
            end
            if (rnd_cnt_q == NR_CNT) begin
              last_rnd_s = 1'b1;
              state_d    = FINISH;
            end else begin
              rnd_cnt_d = rnd_cnt_q + 4'd1;
              state_d   = SBOX;
            end
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end

      FINISH: begin
        busy_s = 1'b0;
        case (op_q)
          OP_DEC, OP_DECLAST, OP_DECFULL: begin
            plain_ready_s = 1'b1;
          end
          OP_IMC: begin
            key_ready_s = 1'b1;
          end
          default: begin
            plain_ready_s = 1'b0;
          end
        endcase
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // abort of a running command: back to reset values, no ready pulse
    if (abort_s && (state_q != IDLE)) begin
      state_d       = IDLE;
      op_d          = OP_NOOP;
      rnd_cnt_d     = 4'd0;
      rcon_d        = RCON_LAST;
      plain_ready_s = 1'b0;
      key_ready_s   = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // Controller state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      op_q      <= OP_NOOP;
      rnd_cnt_q <= 4'd0;
      rcon_q    <= RCON_LAST;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rnd_cnt_q <= rnd_cnt_d;
      rcon_q    <= rcon_d;
    end
  end

  assign first_rnd_o   = first_rnd_s;
  assign last_rnd_o    = last_rnd_s;
  assign key_sel_o     = key_sel_s;
  assign imc_only_o    = imc_only_s;
  assign key_sub_o     = key_sub_s;
  assign inv_key_o     = inv_key_s;
  assign en_rnd_o      = en_rnd_s;
  assign en_key_o      = en_key_s;
  assign plain_ready_o = plain_ready_s;
  assign key_ready_o   = key_ready_s;
  assign busy_o        = busy_s;
  assign r_con_ctrl_o  = {rcon_q, 24'h00_0000};

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_dec_ctrl
// Self-checking bench for aes_dec_ctrl. A timeline model (active opcode plus
// cycle index since the start cycle) predicts every output on every cycle;
// the rcon value is predicted from a literal table of the inverse round
// constants, and ready latencies are pinned to literal cycle counts.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aes_dec_ctrl;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  opcode_i = 3'd0;
  logic        ab_s;
  logic        first_rnd_o, last_rnd_o, key_sel_o, imc_only_o, key_sub_o;
  logic        inv_key_o, en_rnd_o, en_key_o, plain_ready_o, key_ready_o, busy_o;
  logic [31:0] r_con_ctrl_o;

`ifdef AES_DEC_ABORT_EN
  logic abort_i = 1'b0;
  assign ab_s = abort_i;
`else
  assign ab_s = 1'b0;
`endif

  aes_dec_ctrl dut (
    .clk           (clk),
    .nrst          (nrst),
    .start_i       (start_i),
    .opcode_i      (opcode_i),
`ifdef AES_DEC_ABORT_EN
    .abort_i       (abort_i),
`endif
    .first_rnd_o   (first_rnd_o),
    .last_rnd_o    (last_rnd_o),
    .key_sel_o     (key_sel_o),
    .imc_only_o    (imc_only_o),
    .key_sub_o     (key_sub_o),
    .inv_key_o     (inv_key_o),
    .en_rnd_o      (en_rnd_o),
    .en_key_o      (en_key_o),
    .plain_ready_o (plain_ready_o),
    .key_ready_o   (key_ready_o),
    .busy_o        (busy_o),
    .r_con_ctrl_o  (r_con_ctrl_o)
  );

  always #5 clk = ~clk;

  // Inverse key-schedule round constants, K10->K9 first
  localparam logic [7:0] RCON_TAB [10] = '{8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                           8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Cycles from start cycle (T0) to the ready cycle
  function automatic int len_of(input logic [2:0] op);
    case (op)
      3'd1, 3'd2: return 3;
      3'd3:       return 2;
      3'd4:       return 21;
      default:    return 1;
    endcase
  endfunction

  // Model: active command and cycle index; m_rv says rcon is known to be 0x36
  logic [2:0] m_op = 3'd0;
  int         m_t  = 0;
  logic       m_rv = 1'b1;

  // Model timeline advance
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_op <= 3'd0; m_t <= 0; m_rv <= 1'b1;
    end else if (m_op == 3'd0) begin
      if (!ab_s && start_i && (opcode_i >= 3'd1) && (opcode_i <= 3'd4)) begin
        m_op <= opcode_i;
        m_t  <= 1;
        if (opcode_i == 3'd4) m_rv <= 1'b0;
      end
    end else if (ab_s) begin
      m_op <= 3'd0; m_t <= 0; m_rv <= 1'b1;
    end else if (m_t == len_of(m_op)) begin
      m_op <= 3'd0; m_t <= 0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  logic e_f, e_l, e_ks, e_im, e_ksb, e_iv, e_er, e_ek, e_pr, e_kr, e_b;
  int   e_lat;

  // Compare process: every output every cycle, on the falling edge
  always @(negedge clk) begin
    e_f = 1'b0; e_l = 1'b0; e_ks = 1'b0; e_im = 1'b0; e_ksb = 1'b0; e_iv = 1'b0;
    e_er = 1'b1; e_ek = 1'b1; e_pr = 1'b0; e_kr = 1'b0; e_b = 1'b0;
    if (m_op == 3'd0) begin
      if (nrst && !ab_s && start_i && (opcode_i >= 3'd1) && (opcode_i <= 3'd4)) begin
        e_b = 1'b1;
        case (opcode_i)
          3'd1, 3'd2: e_ek = 1'b0;
          3'd3:       e_er = 1'b0;
          default:    e_f  = 1'b1;
        endcase
      end
    end else if (m_t == len_of(m_op)) begin
      e_pr = (m_op != 3'd3) && !ab_s;
      e_kr = (m_op == 3'd3) && !ab_s;
    end else begin
      e_b = 1'b1;
      if (m_op == 3'd3) e_im = 1'b1;
      else if (m_op == 3'd4) begin
        if ((m_t % 2) == 1) begin e_ksb = 1'b1; e_iv = 1'b1; e_er = 1'b0; end
        else begin e_ks = 1'b1; e_l = (m_t == 20); end
      end else if (m_t == 2) e_l = (m_op == 3'd2);
    end
    chk("outputs",
        {21'd0, first_rnd_o, last_rnd_o, key_sel_o, imc_only_o, key_sub_o, inv_key_o,
         en_rnd_o, en_key_o, plain_ready_o, key_ready_o, busy_o},
        {21'd0, e_f, e_l, e_ks, e_im, e_ksb, e_iv, e_er, e_ek, e_pr, e_kr, e_b});

    if ((m_op == 3'd4) && ((m_t % 2) == 1) && (m_t < 21))
      chk("rcon_step", r_con_ctrl_o, {RCON_TAB[(m_t - 1) / 2], 24'd0});
    else if (m_rv)
      chk("rcon_hold", r_con_ctrl_o, 32'h3600_0000);

    if (plain_ready_o || key_ready_o) begin
      case (m_op)
        3'd1, 3'd2: e_lat = 3;
        3'd3:       e_lat = 2;
        3'd4:       e_lat = 21;
        default:    e_lat = -1;
      endcase
      chk("ready_latency", m_t, e_lat);
    end

    if (!nrst) chk("reset_pin", {r_con_ctrl_o[31:1], busy_o}, {31'h1b00_0000, 1'b0});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] opc);
    start_i = 1'b1; opcode_i = opc;
    tick(1);
    start_i = 1'b0; opcode_i = 3'd0;
  endtask

  initial begin
    tick(3);
    nrst = 1'b1;
    tick(2);
    // reset asserted in the middle of a DECFULL
    issue(3'd4); tick(7);
    nrst = 1'b0; tick(2);
    nrst = 1'b1; tick(2);
    // complete DECFULL, stray start at T5 must be ignored
    issue(3'd4); tick(4); issue(3'd1); tick(17);
    // AESDEC, stray start in SBOX, then AESDECLAST the cycle after FINISH
    issue(3'd1); issue(3'd3); tick(2);
    issue(3'd2); tick(4);
    // AESIMC with start held high: re-accepted only once back in IDLE
    start_i = 1'b1; opcode_i = 3'd3; tick(4);
    start_i = 1'b0; opcode_i = 3'd0; tick(4);
    // NOOP and illegal opcodes
    for (int o = 0; o < 8; o++) begin
      if ((o == 0) || (o > 4)) begin issue(3'(o)); tick(1); end
    end
`ifdef AES_DEC_ABORT_EN
    // abort at T9 of a DECFULL, then a clean DECFULL
    issue(3'd4); tick(8);
    abort_i = 1'b1; tick(1); abort_i = 1'b0; tick(2);
    issue(3'd4); tick(22);
    // abort in IDLE beats start
    abort_i = 1'b1; issue(3'd4); abort_i = 1'b0; tick(2);
    // abort in FINISH suppresses the ready pulse
    issue(3'd1); tick(2);
    abort_i = 1'b1; tick(1); abort_i = 1'b0; tick(2);
`endif
    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
